// File: rtl/lfsr_rng_pkg.sv
// Shared types and constants for the LFSR random-number controller/arbiter.
package lfsr_rng_pkg;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT_C = 32'h0000_0001;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PW-1:0]      idx,
  output logic               any
);
  always_comb begin
    idx = '0;
    any = |req;
    // Scan from the farthest position down so the last hit is the closest to ptr.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) idx = PW'(j);
    end
    onehot = any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : '0;
  end
endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Seeds/guards an external 32-bit LFSR and hands fresh words to NUM_REQ requesters round-robin.
// Optional warm-up after each load: define LFSR_RNG_WARMUP_EN.
module lfsr_rng_arbiter
  import lfsr_rng_pkg::*;
#(
  parameter int                NUM_REQ       = 4,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT  = SEED_DEFAULT_C,
  parameter int                WARMUP_CYCLES = 32
) (
  input  logic                Clk,
  input  logic                ARst,
  input  logic                SeedWr,
  input  logic [LFSR_W-1:0]   SeedIn,
  input  logic [NUM_REQ-1:0]  Req,
  output logic [NUM_REQ-1:0]  Gnt,
  output logic [LFSR_W-1:0]   RndData,
  output logic                RndValid,
  output logic                Ready,
  output logic                ZeroErr,
  output logic                LfsrEnable,
  output logic                LfsrLoad,
  output logic [LFSR_W-1:0]   LfsrSeed,
  input  logic [LFSR_W-1:0]   LfsrValue
);
  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || SEED_DEFAULT == '0 || WARMUP_CYCLES < 1) begin : g_param_check
    $error("lfsr_rng_arbiter: illegal parameter value");
  end

  state_t             state, state_nxt;
  logic [LFSR_W-1:0]  seed_reg;
  logic [PW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [PW-1:0]      win_idx;
  logic               req_any;
  logic               lfsr_zero;
  logic               win;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req    (Req),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (req_any)
  );

  assign lfsr_zero = (LfsrValue == '0);
  // A reseed pre-empts arbitration; a zero LFSR never produces a word.
  assign win = (state == RUN) && !SeedWr && req_any && !lfsr_zero;

`ifdef LFSR_RNG_WARMUP_EN
  localparam int     CW         = $clog2(WARMUP_CYCLES + 1);
  localparam state_t AFTER_LOAD = WARMUP;
  logic [CW-1:0] warm_cnt;
  logic          warm_done;

  assign warm_done = (warm_cnt == CW'(WARMUP_CYCLES - 1));

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst)                 warm_cnt <= '0;
    else if (state != WARMUP) warm_cnt <= '0;
    else                      warm_cnt <= warm_cnt + 1'b1;
  end
`else
  localparam state_t AFTER_LOAD = RUN;
`endif

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) state <= LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (SeedWr) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    state_nxt = AFTER_LOAD;
`ifdef LFSR_RNG_WARMUP_EN
        WARMUP:  if (warm_done) state_nxt = RUN;
`endif
        RUN:     if (lfsr_zero) state_nxt = LOAD;
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_comb begin
    LfsrLoad   = (state == LOAD);
    LfsrSeed   = seed_reg;
    Ready      = (state == RUN);
    LfsrEnable = win;
`ifdef LFSR_RNG_WARMUP_EN
    if (state == WARMUP && !SeedWr) LfsrEnable = 1'b1;
`endif
  end

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      seed_reg <= SEED_DEFAULT;
      rr_ptr   <= '0;
      Gnt      <= '0;
      RndValid <= 1'b0;
      RndData  <= '0;
      ZeroErr  <= 1'b0;
    end else begin
      if (SeedWr) seed_reg <= (SeedIn == '0) ? SEED_DEFAULT : SeedIn;
      Gnt      <= win ? win_oh : '0;
      RndValid <= win;
      if (win) begin
        RndData <= LfsrValue;
        rr_ptr  <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (SeedWr)                         ZeroErr <= 1'b0;
      else if (state == RUN && lfsr_zero) ZeroErr <= 1'b1;
    end
  end
endmodule
